regfile_scan_reader: RTL
========================

REGFILE_SCAN_READER -- requirements
Module: regfile_scan_reader

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of storage words; power of two, 2..256.
REQ-003 Parameter ADDR_W, default 3: address width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1: clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 wr_en  input  1: write strobe for the storage array.
REQ-007 wr_addr  input  ADDR_W: write address.
REQ-008 wr_data  input  WIDTH: write data.
REQ-009 start  input  1: request one full scan of addresses 0..DEPTH-1.
REQ-010 out_ready  input  1: downstream accepts the current word.
REQ-011 out_valid  output  1: out_data/out_addr/out_last hold a valid word.
REQ-012 out_data  output  WIDTH: word being streamed.
REQ-013 out_addr  output  ADDR_W: address of out_data.
REQ-014 out_last  output  1: current word is address DEPTH-1.
REQ-015 busy  output  1: scan in progress.
REQ-016 done  output  1: one-cycle pulse after the last word is accepted.

Function
REQ-017 Storage SHALL be DEPTH x WIDTH registers; wr_en=1 at an edge stores wr_data at mem[wr_addr]; writes are accepted in every state.
REQ-018 FSM SHALL have states IDLE and SEND; busy=1 exactly in SEND.
REQ-019 IDLE, start=1 at edge N: go to SEND, ptr=0; from edge N onward out_valid=1, out_addr=0, out_data=mem[0].
REQ-020 start SHALL be ignored while in SEND.
REQ-021 Handshake SHALL occur at an edge where out_valid=1 and out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_addr and out_last SHALL stay constant, including across writes to any address.
REQ-023 Handshake on a non-last word: ptr increments; out_data loads mem[ptr+1] at the same edge; out_valid stays 1 (one word per cycle at full throughput).
REQ-024 Handshake on the last word (ptr=DEPTH-1): out_valid=0, state returns to IDLE, and done=1 for exactly the next cycle.
REQ-025 Output register loads (REQ-019, REQ-023) SHALL forward wr_data when wr_en=1 and wr_addr equals the address being loaded at the same edge.
REQ-026 A write to an address not yet loaded SHALL be visible when that address is streamed; a write to an already-streamed address SHALL NOT be re-sent.
REQ-027 out_last SHALL be 1 iff out_valid=1 and out_addr=DEPTH-1.
REQ-028 A full scan with out_ready held at 1 SHALL take DEPTH cycles from the first out_valid cycle to the last handshake.
REQ-029 start=1 in the cycle done=1 (state IDLE) SHALL begin a new scan per REQ-019.
REQ-030 DEPTH handshakes SHALL occur per scan, in strictly ascending address order, with no gaps and no repeats.

Reset
REQ-031 Reset SHALL immediately clear all mem words to 0, state to IDLE, ptr to 0, out_valid, out_last, busy and done to 0, and out_data and out_addr to 0.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release, the first handshake SHALL come only from a new start.
REQ-033 wr_en and start SHALL be ignored while reset=1.

Verification
REQ-034 Scenario: write mem[i]=8'h10+i for i=0..7, start, out_ready=1 -> 8 consecutive valid cycles with data 10..17 and addr 0..7, out_last on 17, then a single done pulse.
REQ-035 Scenario: same scan with out_ready toggling 1,0,0,1... -> out_data held stable while stalled; sequence 10..17 unchanged, no duplicates.
REQ-036 Scenario: stall on addr 2, write mem[2]=AA and mem[5]=BB during the stall -> addr 2 still shows 12; addr 5 shows BB.
REQ-037 Scenario: handshake on addr 3 in the same cycle as wr_en, wr_addr=4, wr_data=CC -> next word addr 4 = CC (forwarding).
REQ-038 Scenario: assert reset at addr 5 of a scan -> all outputs 0 immediately, no done pulse; a new start after release streams all zeros.
REQ-039 Scenario: start pulsed mid-scan, and start pulsed in the done cycle -> mid-scan pulse has no effect; done-cycle pulse starts a second scan with addr 0 on the next cycle.

Source files
------------

// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader: a DEPTH x WIDTH register file that can be written at any
// time and, on request, streams every word out in ascending address order over
// a valid/ready handshake. The output register is loaded from the array one
// word ahead of time. A write that lands on the word being loaded at the same
// edge is forwarded, so the newest value goes out.
module regfile_scan_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_last_r;
  logic              busy_r;
  logic              done_r;

  logic [ADDR_W-1:0] load_addr_s;
  logic [WIDTH-1:0]  load_data_s;
  logic              handshake_s;
  logic              at_last_s;

  // Returns the array word at addr, replaced by the write data on a same-edge write to it
  function automatic logic [WIDTH-1:0] fwd_word(
    input logic [WIDTH-1:0]  stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic [ADDR_W-1:0] raddr
  );
    logic [WIDTH-1:0] result;
    if (we && (waddr == raddr)) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // Address the output register loads next: word 0 when a scan starts, else the successor of ptr
  always_comb begin
    load_addr_s = ZERO_ADDR;
    if (state_r == SEND) begin
      load_addr_s = ptr_r + ONE_ADDR;
    end else begin
      load_addr_s = ZERO_ADDR;
    end
  end

  // Data for the next output load, with same-edge write forwarding
  always_comb begin
    load_data_s = fwd_word(mem_r[load_addr_s], wr_en, wr_addr, wr_data, load_addr_s);
  end

  // Handshake and end-of-scan decode
  always_comb begin
    handshake_s = 1'b0;
    at_last_s   = 1'b0;
    if (out_valid_r && out_ready) begin
      handshake_s = 1'b1;
    end else begin
      handshake_s = 1'b0;
    end
    if (ptr_r == LAST_ADDR) begin
      at_last_s = 1'b1;
    end else begin
      at_last_s = 1'b0;
    end
  end

  // Storage array: cleared by reset, written whenever wr_en is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Scan FSM with registered stream outputs, busy and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= ZERO_ADDR;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_addr_r  <= ZERO_ADDR;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= SEND;
            ptr_r       <= ZERO_ADDR;
            out_valid_r <= 1'b1;
            out_addr_r  <= ZERO_ADDR;
            out_data_r  <= load_data_s;
            out_last_r  <= (ZERO_ADDR == LAST_ADDR);
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (handshake_s && at_last_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else if (handshake_s) begin
            ptr_r      <= load_addr_s;
            out_addr_r <= load_addr_s;
            out_data_r <= load_data_s;
            out_last_r <= (load_addr_s == LAST_ADDR);
          end else begin
            state_r <= SEND;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
